// File: rtl/max_track4_pkg.sv
// ============================================================================
// max_track4_pkg : shared state encodings and defaults for max_track4
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package max_track4_pkg;

  localparam int CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage : max_track4_pkg

`default_nettype wire

// File: rtl/max_track4_if.sv
// ============================================================================
// max_track4_if : sample stream + result bundle for max_track4
// Optional min outputs present when MAX_TRACK4_MIN_EN is defined.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface max_track4_if #(
  parameter int CNT_W = max_track4_pkg::CNT_W_DEFAULT
);
  logic             start;
  logic             s_valid;
  logic [3:0]       s_data;
  logic             s_last;
  logic             s_ready;
  logic             done;
  logic             done_ack;
  logic [3:0]       max_val;
  logic [CNT_W-1:0] max_idx;
  logic [CNT_W-1:0] count;
  logic             sat;
`ifdef MAX_TRACK4_MIN_EN
  logic [3:0]       min_val;
  logic [CNT_W-1:0] min_idx;

  modport master (
    output start, s_valid, s_data, s_last, done_ack,
    input  s_ready, done, max_val, max_idx, count, sat, min_val, min_idx
  );
  modport slave (
    input  start, s_valid, s_data, s_last, done_ack,
    output s_ready, done, max_val, max_idx, count, sat, min_val, min_idx
  );
`else
  modport master (
    output start, s_valid, s_data, s_last, done_ack,
    input  s_ready, done, max_val, max_idx, count, sat
  );
  modport slave (
    input  start, s_valid, s_data, s_last, done_ack,
    output s_ready, done, max_val, max_idx, count, sat
  );
`endif
endinterface : max_track4_if

`default_nettype wire

// File: rtl/comp_gt4.sv
// ============================================================================
// comp_gt4 : 4-bit unsigned greater-than comparator (gt = a > b)
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module comp_gt4 (
  input  wire logic [3:0] a,
  input  wire logic [3:0] b,
  output logic            gt
);
  assign gt = (a > b);
endmodule : comp_gt4

`default_nettype wire

// File: rtl/max_track4.sv
// ============================================================================
// max_track4 : streaming peak detector for 4-bit unsigned sample frames.
// Optional min tracking enabled by macro MAX_TRACK4_MIN_EN.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module max_track4
  import max_track4_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  wire logic    clk,
  input  wire logic    reset,
  max_track4_if.slave  bus
);

  state_e           state_q, state_d;
  logic             first_q, first_d;
  logic [3:0]       max_val_q, max_val_d;
  logic [CNT_W-1:0] max_idx_q, max_idx_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;
  logic             gt_max;
  logic             accept;
  logic [CNT_W-1:0] idx_next;

  comp_gt4 u_gt_max (
    .a  (bus.s_data),
    .b  (max_val_q),
    .gt (gt_max)
  );

`ifdef MAX_TRACK4_MIN_EN
  logic [3:0]       min_val_q, min_val_d;
  logic [CNT_W-1:0] min_idx_q, min_idx_d;
  logic             gt_min;

  comp_gt4 u_gt_min (
    .a  (min_val_q),
    .b  (bus.s_data),
    .gt (gt_min)
  );
`endif

  assign accept   = bus.s_valid & bus.s_ready;
  // Index of the sample being accepted now (valid for every sample after the first).
  assign idx_next = count_q + {{(CNT_W-1){1'b0}}, 1'b1};

  always_comb begin
    state_d   = state_q;
    first_d   = first_q;
    max_val_d = max_val_q;
    max_idx_d = max_idx_q;
    count_d   = count_q;
    sat_d     = sat_q;
`ifdef MAX_TRACK4_MIN_EN
    min_val_d = min_val_q;
    min_idx_d = min_idx_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_TRACK;
          first_d   = 1'b1;
          max_val_d = '0;
          max_idx_d = '0;
          count_d   = '0;
          sat_d     = 1'b0;
`ifdef MAX_TRACK4_MIN_EN
          min_val_d = '0;
          min_idx_d = '0;
`endif
        end
      end
      ST_TRACK: begin
        if (accept) begin
          if (first_q) begin
            first_d   = 1'b0;
            max_val_d = bus.s_data;
            max_idx_d = '0;
`ifdef MAX_TRACK4_MIN_EN
            min_val_d = bus.s_data;
            min_idx_d = '0;
`endif
            if (bus.s_last) state_d = ST_DONE;
          end else begin
            count_d = idx_next;
            // Strict compare: ties keep the earliest index.
            if (gt_max) begin
              max_val_d = bus.s_data;
              max_idx_d = idx_next;
            end
`ifdef MAX_TRACK4_MIN_EN
            if (gt_min) begin
              min_val_d = bus.s_data;
              min_idx_d = idx_next;
            end
`endif
            if (bus.s_last) begin
              state_d = ST_DONE;
            end else if (&idx_next) begin
              state_d = ST_DONE;
              sat_d   = 1'b1;
            end
          end
        end
      end
      ST_DONE: begin
        if (bus.done_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      first_q   <= 1'b1;
      max_val_q <= '0;
      max_idx_q <= '0;
      count_q   <= '0;
      sat_q     <= 1'b0;
`ifdef MAX_TRACK4_MIN_EN
      min_val_q <= '0;
      min_idx_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      first_q   <= first_d;
      max_val_q <= max_val_d;
      max_idx_q <= max_idx_d;
      count_q   <= count_d;
      sat_q     <= sat_d;
`ifdef MAX_TRACK4_MIN_EN
      min_val_q <= min_val_d;
      min_idx_q <= min_idx_d;
`endif
    end
  end

  assign bus.s_ready = (state_q == ST_TRACK);
  assign bus.done    = (state_q == ST_DONE);
  assign bus.max_val = max_val_q;
  assign bus.max_idx = max_idx_q;
  assign bus.count   = count_q;
  assign bus.sat     = sat_q;
`ifdef MAX_TRACK4_MIN_EN
  assign bus.min_val = min_val_q;
  assign bus.min_idx = min_idx_q;
`endif

endmodule : max_track4

`default_nettype wire

// File: tb/tb_max_track4.sv
// ============================================================================
// tb_max_track4 : directed self-checking bench for max_track4 (CNT_W = 3)
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_max_track4;

  localparam int CNT_W = 3;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  max_track4_if #(.CNT_W(CNT_W)) bus ();

  max_track4 #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Present one sample and hold it until accepted (bounded).
  task automatic send(input logic [3:0] d, input logic last);
    bit ok;
    ok = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (bus.s_ready === 1'b1) ok = 1'b1;
      tick();
    end
    if (!ok) check_eq("send_timeout", 32'(ok), 32'd1);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic ack();
    bus.done_ack = 1'b1;
    tick();
    bus.done_ack = 1'b0;
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.s_valid  = 1'b0;
    bus.s_data   = 4'd0;
    bus.s_last   = 1'b0;
    bus.done_ack = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    check_eq("rst_ready", 32'(bus.s_ready), 32'd0);
    check_eq("rst_done",  32'(bus.done),    32'd0);
    check_eq("rst_max",   32'(bus.max_val), 32'd0);
    check_eq("rst_idx",   32'(bus.max_idx), 32'd0);
    check_eq("rst_count", 32'(bus.count),   32'd0);
    check_eq("rst_sat",   32'(bus.sat),     32'd0);

    // Basic frame 3 9 2 9 5
    do_start();
    check_eq("trk_ready", 32'(bus.s_ready), 32'd1);
    send(4'd3, 1'b0);
    check_eq("b_lat_max", 32'(bus.max_val), 32'd3);
    send(4'd9, 1'b0);
    send(4'd2, 1'b0);
    send(4'd9, 1'b0);
    send(4'd5, 1'b1);
    check_eq("b_done",  32'(bus.done),    32'd1);
    check_eq("b_max",   32'(bus.max_val), 32'd9);
    check_eq("b_idx",   32'(bus.max_idx), 32'd1);
    check_eq("b_count", 32'(bus.count),   32'd4);
    check_eq("b_sat",   32'(bus.sat),     32'd0);
    ack();
    check_eq("ack_done",  32'(bus.done),    32'd0);
    check_eq("ack_ready", 32'(bus.s_ready), 32'd0);
    check_eq("ack_hold",  32'(bus.max_val), 32'd9);

    // All-zero frame
    do_start();
    check_eq("clr_max",   32'(bus.max_val), 32'd0);
    check_eq("clr_count", 32'(bus.count),   32'd0);
    send(4'd0, 1'b0);
    send(4'd0, 1'b0);
    send(4'd0, 1'b1);
    check_eq("z_max",   32'(bus.max_val), 32'd0);
    check_eq("z_idx",   32'(bus.max_idx), 32'd0);
    check_eq("z_count", 32'(bus.count),   32'd2);
    ack();

    // Bubbles between samples, then a held result
    do_start();
    send(4'd1, 1'b0);
    tick();
    send(4'd15, 1'b0);
    tick();
    send(4'd15, 1'b0);
    tick();
    send(4'd4, 1'b1);
    for (int c = 0; c < 5; c++) begin
      bus.start = (c == 2);
      check_eq("h_done",  32'(bus.done),    32'd1);
      check_eq("h_ready", 32'(bus.s_ready), 32'd0);
      check_eq("h_max",   32'(bus.max_val), 32'd15);
      check_eq("h_idx",   32'(bus.max_idx), 32'd1);
      check_eq("h_count", 32'(bus.count),   32'd3);
      tick();
    end
    // start alongside done_ack must not begin a frame
    bus.start = 1'b1;
    ack();
    bus.start = 1'b0;
    check_eq("ack_start_ready", 32'(bus.s_ready), 32'd0);
    check_eq("ack_start_max",   32'(bus.max_val), 32'd15);

    // Saturation: 8 samples without s_last
    do_start();
    for (int i = 0; i < 8; i++) send(4'(i), 1'b0);
    check_eq("s_done",  32'(bus.done),    32'd1);
    check_eq("s_sat",   32'(bus.sat),     32'd1);
    check_eq("s_count", 32'(bus.count),   32'd7);
    check_eq("s_max",   32'(bus.max_val), 32'd7);
    check_eq("s_idx",   32'(bus.max_idx), 32'd7);
    ack();

    // Single-sample frame
    do_start();
    check_eq("clr_sat", 32'(bus.sat), 32'd0);
    send(4'd11, 1'b1);
    check_eq("one_done",  32'(bus.done),    32'd1);
    check_eq("one_max",   32'(bus.max_val), 32'd11);
    check_eq("one_idx",   32'(bus.max_idx), 32'd0);
    check_eq("one_count", 32'(bus.count),   32'd0);
    ack();

    // Reset mid-frame
    do_start();
    send(4'd1, 1'b0);
    send(4'd2, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mr_ready", 32'(bus.s_ready), 32'd0);
    check_eq("mr_max",   32'(bus.max_val), 32'd0);
    check_eq("mr_idx",   32'(bus.max_idx), 32'd0);
    check_eq("mr_count", 32'(bus.count),   32'd0);
    do_start();
    send(4'd6, 1'b0);
    send(4'd2, 1'b1);
    check_eq("mr2_max",   32'(bus.max_val), 32'd6);
    check_eq("mr2_idx",   32'(bus.max_idx), 32'd0);
    check_eq("mr2_count", 32'(bus.count),   32'd1);
    ack();

`ifdef MAX_TRACK4_MIN_EN
    do_start();
    send(4'd7, 1'b0);
    send(4'd3, 1'b0);
    send(4'd12, 1'b0);
    send(4'd3, 1'b1);
    check_eq("mn_min",  32'(bus.min_val), 32'd3);
    check_eq("mn_midx", 32'(bus.min_idx), 32'd1);
    check_eq("mn_max",  32'(bus.max_val), 32'd12);
    check_eq("mn_xidx", 32'(bus.max_idx), 32'd2);
    ack();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_max_track4

`default_nettype wire
